// File: rtl/fir_tdm_pkg.sv
// fir_tdm_pkg: shared FSM states, accumulator sizing and pipeline depth for the TDM FIR
package fir_tdm_pkg;
    typedef enum logic [1:0] {CLEAR, IDLE, MAC, DRAIN} state_t;
    localparam int PIPE_DEPTH = 3;
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction
endpackage

// File: rtl/fir_mac_pipe.sv
// fir_mac_pipe: operand/product/accumulate pipeline plus output narrowing (saturate when FIR_SAT_EN, else wrap)
module fir_mac_pipe
    import fir_tdm_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 18,
    parameter int NUM_TAPS   = 32,
    parameter int OUT_SHIFT  = 17
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         vld_i,
    input  logic                         first_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [COEF_WIDTH-1:0] h_i,
    output logic signed [DATA_WIDTH-1:0] dout_o,
    output logic                         ovf_o
);
    localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    logic signed [DATA_WIDTH-1:0] x_q;
    logic signed [COEF_WIDTH-1:0] h_q;
    logic signed [PW-1:0]         prod_q;
    logic signed [ACC_W-1:0]      acc_q, sh;
    logic                         v1_q, f1_q, v2_q, f2_q;
    // operand, product and accumulate stages advance together; first tap restarts the sum
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            x_q    <= '0;
            h_q    <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            v1_q   <= 1'b0;
            f1_q   <= 1'b0;
            v2_q   <= 1'b0;
            f2_q   <= 1'b0;
        end else if (en_i) begin
            x_q    <= x_i;
            h_q    <= h_i;
            v1_q   <= vld_i;
            f1_q   <= first_i;
            prod_q <= x_q * h_q;
            v2_q   <= v1_q;
            f2_q   <= f1_q;
            if (v2_q) acc_q <= f2_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
        end
    assign sh = acc_q >>> OUT_SHIFT;
    assign ovf_o = sh[ACC_W-1:DATA_WIDTH-1] != {(ACC_W-DATA_WIDTH+1){sh[DATA_WIDTH-1]}};
`ifdef FIR_SAT_EN
    assign dout_o = ovf_o ? {sh[ACC_W-1], {(DATA_WIDTH-1){~sh[ACC_W-1]}}} : sh[DATA_WIDTH-1:0];
`else
    assign dout_o = sh[DATA_WIDTH-1:0];
`endif
endmodule

// File: rtl/fir_tdm_filter.sv
// fir_tdm_filter: multi-channel time-multiplexed FIR, one shared MAC, loadable coefficients (FIR_SAT_EN selects saturation)
module fir_tdm_filter
    import fir_tdm_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 18,
    parameter int NUM_TAPS   = 32,
    parameter int NUM_CH     = 2,
    parameter int OUT_SHIFT  = 17,
    localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int TAP_W = $clog2(NUM_TAPS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [CH_W-1:0]              iv_ch,
    input  logic signed [DATA_WIDTH-1:0] iv_din,
    output logic                         o_valid,
    output logic [CH_W-1:0]              ov_ch,
    output logic signed [DATA_WIDTH-1:0] ov_dout,
    output logic                         o_ovf,
    input  logic                         i_coef_we,
    input  logic [TAP_W-1:0]             iv_coef_addr,
    input  logic signed [COEF_WIDTH-1:0] iv_coef_data,
    output logic                         o_coef_err
);
    state_t                       state_q;
    logic [TAP_W-1:0]             k_q, rd_tap;
    logic [TAP_W-1:0]             wp_q [NUM_CH];
    logic [CH_W-1:0]              ch_q;
    logic signed [DATA_WIDTH-1:0] line_q [NUM_CH][NUM_TAPS];
    logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
    logic                         ready_q, valid_q, coef_err_q;
    logic signed [DATA_WIDTH-1:0] dout_w;
    logic                         ovf_w, accept, ch_ok, coef_ok;
    assign accept  = i_valid && ready_q && i_en;
    assign ch_ok   = 32'(iv_ch) < NUM_CH;
    assign coef_ok = i_coef_we && i_en && state_q == IDLE && !accept;
    assign rd_tap  = wp_q[ch_q] - k_q;
    assign o_ready = ready_q && i_en;
    assign o_valid = valid_q && i_en;
    assign o_coef_err = coef_err_q;
    // control FSM: k_q counts clear entries, MAC taps and drain cycles; outputs are registered
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state_q <= CLEAR;
            k_q     <= '0;
            ch_q    <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            ov_dout <= '0;
            ov_ch   <= '0;
            o_ovf   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) wp_q[i] <= '0;
        end else if (i_en) begin
            valid_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    k_q <= k_q + 1'b1;
                    if (&k_q) ch_q <= ch_q + 1'b1;
                    if (&k_q && 32'(ch_q) == NUM_CH - 1) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        ch_q    <= '0;
                    end
                end
                IDLE: if (accept && ch_ok) begin
                    state_q <= MAC;
                    ready_q <= 1'b0;
                    ch_q    <= iv_ch;
                    k_q     <= '0;
                end
                MAC: begin
                    k_q <= k_q + 1'b1;
                    if (&k_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == TAP_W'(PIPE_DEPTH)) begin
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        valid_q     <= 1'b1;
                        ov_dout     <= dout_w;
                        o_ovf       <= ovf_w;
                        ov_ch       <= ch_q;
                        wp_q[ch_q]  <= wp_q[ch_q] + 1'b1;
                        k_q         <= '0;
                    end
                end
            endcase
        end
    // delay lines and coefficients: zeroed one entry per cycle in CLEAR, then written by accepts/permitted writes
    always_ff @(posedge i_clk) begin
        if (i_en && state_q == CLEAR) begin
            line_q[ch_q][k_q] <= '0;
            coef_q[k_q]       <= '0;
        end
        if (accept && ch_ok) line_q[iv_ch][wp_q[iv_ch]] <= iv_din;
        if (coef_ok) coef_q[iv_coef_addr] <= iv_coef_data;
    end
    // a dropped coefficient write is flagged one cycle later, even while disabled
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) coef_err_q <= 1'b0;
        else coef_err_q <= i_coef_we && !coef_ok;
    fir_mac_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .COEF_WIDTH(COEF_WIDTH),
        .NUM_TAPS  (NUM_TAPS),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mac (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .en_i   (i_en),
        .vld_i  (state_q == MAC),
        .first_i(k_q == '0),
        .x_i    (line_q[ch_q][rd_tap]),
        .h_i    (coef_q[k_q]),
        .dout_o (dout_w),
        .ovf_o  (ovf_w)
    );
endmodule

// File: tb/tb_fir_tdm_filter.sv
// tb_fir_tdm_filter: scoreboard bench with a direct-form FIR reference model
module tb_fir_tdm_filter;
    localparam int DW = 24, CW = 18, NT = 4, NCH = 2, SH = 0, CHW = 1, TW = 2;
    localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW - 1));
    typedef struct {
        int                   ch;
        logic signed [DW-1:0] dout;
        bit                   ovf;
        longint               t;
    } exp_t;
    logic clk = 0, rst = 1, en = 1, valid = 0, ready, ovalid, ovf, coef_we = 0, coef_err;
    logic [CHW-1:0] ch_in = '0, ch_out;
    logic signed [DW-1:0] din = '0, dout;
    logic [TW-1:0] coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    exp_t sb[$];
    exp_t mon_e;
    longint h [NT];
    longint hist [NCH][NT];
    longint ecnt = 0;
    int n_chk = 0, n_fail = 0;

    fir_tdm_filter #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT), .NUM_CH(NCH), .OUT_SHIFT(SH)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .o_ready(ready),
        .iv_ch(ch_in), .iv_din(din), .o_valid(ovalid), .ov_ch(ch_out), .ov_dout(dout),
        .o_ovf(ovf), .i_coef_we(coef_we), .iv_coef_addr(coef_addr),
        .iv_coef_data(coef_data), .o_coef_err(coef_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (en && !rst) ecnt <= ecnt + 1;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint rnd(input int bits);
        return longint'($urandom_range(0, (1 << bits) - 1)) - (longint'(1) << (bits - 1));
    endfunction

    // monitor: sample just before the next rising edge, pop and compare
    always @(negedge clk) begin
        #2;
        if (ovalid) begin
            if (sb.size() == 0) chk(0, "unexpected_valid", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk(int'(ch_out) == mon_e.ch, "ch", longint'(ch_out), mon_e.ch);
                chk(dout == mon_e.dout, "dout", dout, mon_e.dout);
                chk(ovf == mon_e.ovf, "ovf", ovf, mon_e.ovf);
                chk(ecnt == mon_e.t, "latency", ecnt, mon_e.t);
            end
        end
    end

    task automatic send(input int ch, input longint x, input bit ren);
        int t = 0;
        longint s = 0;
        exp_t e;
        do begin
            @(negedge clk);
            en = ren ? ($urandom_range(3) != 0) : 1'b1;
            #1;
            t++;
        end while (!ready && t < 500);
        if (!ready) begin
            chk(0, "ready_timeout", 0, 1);
            return;
        end
        valid = 1; ch_in = CHW'(ch); din = DW'(x);
        @(posedge clk);
        #1;
        valid = 0;
        for (int j = NT - 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
        hist[ch][0] = x;
        for (int k = 0; k < NT; k++) s += h[k] * hist[ch][k];
        s = s >>> SH;
        e.ch = ch;
        e.ovf = s > MAXV || s < MINV;
`ifdef FIR_SAT_EN
        e.dout = e.ovf ? DW'(s > 0 ? MAXV : MINV) : DW'(s);
`else
        e.dout = DW'(s);
`endif
        e.t = ecnt + NT + 4;
        sb.push_back(e);
    endtask

    task automatic wr_coef(input int a, input longint d, input bit exp_err, input bit en_v);
        @(negedge clk);
        coef_we = 1; coef_addr = TW'(a); coef_data = CW'(d); en = en_v;
        @(negedge clk);
        coef_we = 0; en = 1;
        #1;
        chk(coef_err == exp_err, "coef_err", coef_err, exp_err);
        if (!exp_err) h[a] = d;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            en = 1;
            #1;
            t++;
        end while ((sb.size() != 0 || !ready) && t < 1000);
        if (t >= 1000) chk(0, "idle_timeout", sb.size(), 0);
    endtask

    task automatic do_reset();
        int n = 0;
        @(negedge clk);
        rst = 1; valid = 0; coef_we = 0; en = 1;
        sb.delete();
        for (int k = 0; k < NT; k++) h[k] = 0;
        for (int c = 0; c < NCH; c++) for (int k = 0; k < NT; k++) hist[c][k] = 0;
        #1;
        chk(ovalid == 0, "rst_valid", ovalid, 0);
        chk(ready == 0, "rst_ready", ready, 0);
        chk(dout == 0, "rst_dout", dout, 0);
        chk(ch_out == 0, "rst_ch", longint'(ch_out), 0);
        chk(ovf == 0 && coef_err == 0, "rst_flags", ovf, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(n == NCH * NT, "clear_len", n, NCH * NT);
    endtask

    initial begin
        do_reset();
        for (int k = 0; k < NT; k++) wr_coef(k, k + 1, 0, 1);
        for (int i = 0; i < 5; i++) send(0, i == 0 ? 1 : 0, 0);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            send(0, i == 0 ? 1 : 0, 0);
            send(1, i == 0 ? 100 : 0, 0);
        end
        wait_idle();
        send(0, 5, 0);
        wr_coef(0, 7, 1, 1);
        send(0, 0, 0);
        wait_idle();
        wr_coef(1, 9, 1, 0);
        send(0, 1, 0);
        repeat (NT + 1) @(negedge clk);
        en = 0;
        repeat (10) @(negedge clk);
        en = 1;
        wait_idle();
        for (int k = 0; k < NT; k++) wr_coef(k, 'h1FFFF, 0, 1);
        for (int i = 0; i < NT; i++) send(0, 'h7FFFFF, 0);
        wait_idle();
        send(0, 1, 0);
        repeat (2) @(negedge clk);
        do_reset();
        send(0, 1, 0);
        wait_idle();
        for (int k = 0; k < NT; k++) wr_coef(k, rnd(8), 0, 1);
        repeat (30) send($urandom_range(NCH - 1), rnd(12), 1);
        wait_idle();
        for (int k = 0; k < NT; k++) wr_coef(k, rnd(CW), 0, 1);
        repeat (20) send($urandom_range(NCH - 1), rnd(DW), 1);
        wait_idle();
        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
